// File: rtl/ones_count_sequencer.sv
// Feeds data words from a small FIFO into the shift-and-count ones counter one job
// at a time and returns {word, count} on a valid/ready result stream.
module ones_count_sequencer #(
    parameter int r1_size    = 8,
    parameter int r2_size    = 4,
    parameter int fifo_depth = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [r1_size-1:0] in_data,
    output logic               cnt_rstb,
    output logic               cnt_start,
    output logic [r1_size-1:0] cnt_data,
    input  logic               cnt_rdy,
    input  logic [r2_size-1:0] cnt_count,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [r1_size-1:0] out_data,
    output logic [r2_size-1:0] out_count,
    output logic               busy
);

    localparam int AW = $clog2(fifo_depth);
    localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(fifo_depth);
    localparam logic [AW:0]   LEVEL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_BUSY0  = 3'd2,
        ST_BUSY   = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [r1_size-1:0]  fifo_q [fifo_depth];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         level_q;
    logic                cnt_start_q, cnt_start_d;
    logic [r1_size-1:0]  cnt_data_q, cnt_data_d;
    logic                out_valid_q, out_valid_d;
    logic [r1_size-1:0]  out_data_q, out_data_d;
    logic [r2_size-1:0]  out_count_q, out_count_d;
    logic                full, empty, push, pop, slot_free, capture;

    assign full      = (level_q == LEVEL_FULL);
    assign empty     = (level_q == {(AW+1){1'b0}});
    assign push      = in_valid & ~full;
    assign pop       = (state_q == ST_IDLE) & ~empty & cnt_rdy;
    assign slot_free = ~out_valid_q | out_ready;

    // FIFO storage is pure datapath; validity is tracked by level_q
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= in_data;
        end
    end

    // FIFO pointers and fill level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {(AW+1){1'b0}};
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LEVEL_ONE;
                2'b01:   level_q <= level_q - LEVEL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    // Next-state and registered-output logic of the job sequencer
    always_comb begin
        state_d     = state_q;
        cnt_data_d  = cnt_data_q;
        out_valid_d = out_valid_q & ~out_ready;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        capture     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d    = ST_LAUNCH;
                    cnt_data_d = fifo_q[rd_ptr_q];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: state_d = ST_BUSY0;
            // The counter drops rdy at the edge that closes LAUNCH, so rdy is stale here
            ST_BUSY0:  state_d = ST_BUSY;
            ST_BUSY: begin
                if (cnt_rdy) begin
                    if (slot_free) begin
                        capture = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_HOLD: begin
                if (slot_free) begin
                    capture = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (capture) begin
            out_valid_d = 1'b1;
            out_data_d  = cnt_data_q;
            out_count_d = cnt_count;
        end else begin
            out_data_d  = out_data_q;
            out_count_d = out_count_q;
        end
        cnt_start_d = (state_d == ST_LAUNCH);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_start_q <= 1'b0;
            cnt_data_q  <= {r1_size{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {r1_size{1'b0}};
            out_count_q <= {r2_size{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_start_q <= cnt_start_d;
            cnt_data_q  <= cnt_data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

    assign cnt_rstb  = ~rst;
    assign in_ready  = ~full;
    assign cnt_start = cnt_start_q;
    assign cnt_data  = cnt_data_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign busy      = (state_q != ST_IDLE) | ~empty;

endmodule

// File: tb/tb_ones_count_sequencer.sv
// Directed and random bench for ones_count_sequencer with a behavioural
// shift-and-count counter attached to its counter port.
module tb_ones_count_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b1;
    logic       in_ready, cnt_rstb, cnt_start, out_valid, busy;
    logic [7:0] cnt_data, out_data;
    logic [3:0] out_count;
    logic       cnt_rdy;
    logic [3:0] cnt_count;

    int n_vec  = 0;
    int n_miss = 0;

    ones_count_sequencer #(.r1_size(8), .r2_size(4), .fifo_depth(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cnt_rstb(cnt_rstb), .cnt_start(cnt_start), .cnt_data(cnt_data),
        .cnt_rdy(cnt_rdy), .cnt_count(cnt_count),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ones8(input logic [7:0] w);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) c = c + {3'b000, w[i]};
        return c;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counter model: busy for 1 + 2*ones + 8 cycles, count cleared while running
    logic [5:0] left;
    logic [7:0] job_word;
    always @(posedge clk or negedge cnt_rstb) begin
        if (!cnt_rstb) begin
            cnt_rdy   <= 1'b1;
            cnt_count <= 4'd0;
            left      <= 6'd0;
            job_word  <= 8'h00;
        end else if (cnt_start && cnt_rdy) begin
            cnt_rdy   <= 1'b0;
            cnt_count <= 4'd0;
            left      <= 6'd9 + {1'b0, ones8(cnt_data), 1'b0};
            job_word  <= cnt_data;
        end else if (!cnt_rdy) begin
            if (left == 6'd1) begin
                cnt_rdy   <= 1'b1;
                cnt_count <= ones8(job_word);
            end
            left <= left - 6'd1;
        end
    end

    // Handshake monitor; sampled mid-cycle, each record is the transfer at the next rising edge
    logic [7:0]  push_q[$];
    logic [11:0] res_q[$];
    int          n_starts = 0;
    int          n_viol   = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) push_q.push_back(in_data);
            if (out_valid && out_ready) res_q.push_back({out_data, out_count});
            if (cnt_start) begin
                n_starts++;
                if (!cnt_rdy) n_viol++;
            end
        end
    end

    task automatic push_word(input logic [7:0] d);
        int cyc;
        cyc = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 2000) check_eq("push_timeout", cyc, 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_res(input int n);
        int cyc;
        cyc = 0;
        while (res_q.size() < n && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("res_count", res_q.size(), n);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base, s0, cyc, unstable;
        logic [7:0] hd;
        logic [3:0] hc;
        logic [7:0] burst [5];
        bit         done;
        burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'h81; burst[3] = 8'h10; burst[4] = 8'h7E;

        // Reset with in_valid held high
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_cnt_start", cnt_start, 0);
        check_eq("rst_cnt_rstb", cnt_rstb, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_count", out_count, 0);
        check_eq("rst_cnt_data", cnt_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_no_push_busy", busy, 0);
        check_eq("rst_no_push_start", n_starts, 0);

        // Single word 8'hB5 with start timing
        @(posedge clk);
        #1 in_valid = 1'b1;
        in_data = 8'hB5;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check_eq("b5_start_T", cnt_start, 0);
        @(negedge clk);
        check_eq("b5_start_T1", cnt_start, 1);
        check_eq("b5_cnt_data", cnt_data, 8'hB5);
        @(negedge clk);
        check_eq("b5_start_T2", cnt_start, 0);
        wait_res(1);
        check_eq("b5_result", res_q[0], {8'hB5, 4'd5});
        check_eq("b5_one_start", n_starts, 1);

        // Back-to-back burst fills the FIFO while the first job runs
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) push_word(burst[i]);
        @(negedge clk);
        check_eq("burst_full", in_ready, 0);
        wait_res(6);
        for (int i = 0; i < 5; i++)
            check_eq("burst_result", res_q[1+i], {burst[i], ones8(burst[i])});

        // Back-pressure: first result held, second job waits in HOLD
        base = res_q.size();
        s0   = n_starts;
        @(posedge clk);
        #1 out_ready = 1'b0;
        push_word(8'h0F);
        push_word(8'hFF);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("hold_first_seen", out_valid, 1);
        hd = out_data;
        hc = out_count;
        check_eq("hold_first_data", {hd, hc}, {8'h0F, 4'd4});
        unstable = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_data !== hd || out_count !== hc || out_valid !== 1'b1) unstable++;
        end
        check_eq("hold_stable", unstable, 0);
        check_eq("hold_busy", busy, 1);
        check_eq("hold_in_ready", in_ready, 1);
        check_eq("hold_job_done", cnt_rdy, 1);
        check_eq("hold_launches", n_starts - s0, 2);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("hold_second_valid", out_valid, 1);
        check_eq("hold_second", {out_data, out_count}, {8'hFF, 4'd8});
        wait_res(base + 2);
        check_eq("hold_first_res", res_q[base], {8'h0F, 4'd4});

        // Reset two cycles after a start abandons the job
        base = res_q.size();
        @(posedge clk);
        #1;
        push_word(8'hF0);
        cyc = 0;
        while (!cnt_start && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("mid_start_seen", cnt_start, 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_eq("mid_out_valid", out_valid, 0);
        check_eq("mid_cnt_start", cnt_start, 0);
        check_eq("mid_cnt_rstb", cnt_rstb, 0);
        check_eq("mid_cnt_data", cnt_data, 0);
        check_eq("mid_busy", busy, 0);
        check_eq("mid_in_ready", in_ready, 1);
        check_eq("mid_out_bus", {out_data, out_count}, 12'h000);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("mid_no_emit", res_q.size(), base);
        @(posedge clk);
        #1;
        push_word(8'h03);
        wait_res(base + 1);
        check_eq("mid_new_word", res_q[base], {8'h03, 4'd2});

        // Random stream with random output back-pressure
        @(posedge clk);
        #1;
        push_q.delete();
        res_q.delete();
        s0   = n_starts;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    push_word(8'($urandom));
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_res(200);
        check_eq("rand_pushed", push_q.size(), 200);
        for (int i = 0; i < 200 && i < res_q.size() && i < push_q.size(); i++)
            check_eq("rand_result", res_q[i], {push_q[i], ones8(push_q[i])});
        check_eq("rand_starts", n_starts - s0, 200);
        check_eq("start_while_busy", n_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ones_count_sequencer.md
Name: ones_count_sequencer

Overview:
- Upstream feeder and result collector for the shift-and-count ones-counter stage (start/data in, count/rdy out).
- Accepts data words over a valid/ready stream into a small FIFO and launches one counter job per word with a single-cycle start pulse.
- Captures the finished count and presents {data, count} on a valid/ready output stream.
- Owns the counter's reset so that sequencer and counter always restart together.

Parameters:
r1_size, 8, data word width; must equal the counter's r1_size
r2_size, 4, count width; must equal the counter's r2_size; requires 2**r2_size > r1_size
fifo_depth, 4, input FIFO entries; power of 2, minimum 2

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  input word valid
in_ready  output  1  FIFO can accept a word
in_data  input  r1_size  input word
cnt_rstb  output  1  counter reset, active low, equal to ~rst (combinational)
cnt_start  output  1  counter start, registered
cnt_data  output  r1_size  word presented to counter, registered
cnt_rdy  input  1  counter idle/done
cnt_count  input  r2_size  counter result
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  r1_size  word that produced the result
out_count  output  r2_size  number of 1 bits in out_data
busy  output  1  high when state is not IDLE or the FIFO is non-empty

Behaviour:
- Reset: FIFO empty, state IDLE, cnt_start=0, cnt_data=0, out_valid=0, out_data=0, out_count=0, in_ready=1. cnt_rstb=0 while rst is high.
- Reset mid-job: the job is abandoned and never reported; the counter is reset through cnt_rstb.
- FIFO push: on in_valid & in_ready at a clock edge.
- in_ready = ~full. There is no push-through-pop when full.
- Pop: only from IDLE.
- FSM, launch (IDLE -> LAUNCH): when the FIFO is non-empty & cnt_rdy, pop the head into cnt_data at that edge.
- FSM, LAUNCH: cnt_start=1 for exactly one cycle and cnt_data is stable. The counter loads at the closing edge. Unconditionally -> BUSY.
- FSM, BUSY: cnt_rdy is ignored in the first BUSY cycle, because the counter drops rdy at that edge.
  - From the second BUSY cycle onward, cnt_rdy=1 means the job is complete.
  - If the output slot is free (out_valid=0 | out_ready), capture out_data<=cnt_data and out_count<=cnt_count, set out_valid, -> IDLE.
  - Otherwise -> HOLD.
- FSM, HOLD: the counter stays idle and its count is stable. Capture when the slot becomes free, then -> IDLE.
- Output handshake: out_valid is held until out_valid & out_ready.
  - out_data and out_count are stable while out_valid & ~out_ready.
  - Capture and drain in the same cycle leaves out_valid=1 with the new result.
- A launch is never blocked by the output slot; only capture waits.
- cnt_start is never asserted when cnt_rdy=0.
- Minimum per-word latency, word pushed at edge T into an empty FIFO with the counter idle:
  - pop at T+1, start high during T+1..T+2;
  - counter then runs 1 + 2*(number of ones) + shifts cycles;
  - out_valid rises one edge after the first qualifying cnt_rdy in BUSY.
- Ordering: results are produced strictly in input order; there is one job in flight.
- Width: out_count is passed through unmodified from cnt_count, and the all-zero word yields 0.

Test Plan:
- Reset with in_valid=1 held -> in_ready=1, out_valid=0, cnt_start=0, cnt_rstb=0, and no push while rst is high.
- Single word 8'hB5, out_ready=1 -> exactly one cnt_start pulse with cnt_data=8'hB5, then out_valid with out_data=8'hB5 and out_count=4'd5.
- Burst 8'h00, 8'hFF, 8'h81, 8'h10, 8'h7E back-to-back:
  - in_ready drops after 4 entries while the first job runs;
  - results appear in order with counts 0, 8, 2, 1, 6.
- out_ready=0 for 40 cycles after the first result:
  - first result is held stable;
  - second job completes and the FSM sits in HOLD;
  - out_ready=1 -> second result (8'hFF, 8) appears on the next edge.
- rst asserted two cycles after a cnt_start:
  - all outputs return to reset values;
  - the in-flight result is never emitted;
  - new word 8'h03 after release yields count 2.
- Random stream of 200 words with random out_ready -> every out_count equals the popcount of out_data, no word is lost or duplicated, and cnt_start is never seen while cnt_rdy=0.
